// File: rtl/branch_pkg.sv
// Shared types and constants for the branch predictor.
// Holds the resolve opcode enum and the 2-bit saturating counter states.
package branch_pkg;

    typedef enum logic [2:0] {
        OP_JAL  = 3'd0,
        OP_JALR = 3'd1,
        OP_BEQ  = 3'd2,
        OP_BNE  = 3'd3,
        OP_BLT  = 3'd4,
        OP_BGE  = 3'd5,
        OP_BLTU = 3'd6,
        OP_BGEU = 3'd7
    } branch_op_t;

    // Counter states: strongly/weakly not-taken, weakly/strongly taken.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator: decides taken/not-taken from rs1, rs2 and the opcode.
// Jumps are always taken; B-type ops compare operand_1 against operand_2.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    input  branch_op_t      op,
    output logic            taken
);

    // Condition decode; signed ops reinterpret the operands as two's complement.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_JAL, OP_JALR: taken = 1'b1;
            OP_BEQ:          taken = (operand_1 == operand_2);
            OP_BNE:          taken = (operand_1 != operand_2);
            OP_BLT:          taken = ($signed(operand_1) <  $signed(operand_2));
            OP_BGE:          taken = ($signed(operand_1) >= $signed(operand_2));
            OP_BLTU:         taken = (operand_1 <  operand_2);
            OP_BGEU:         taken = (operand_1 >= operand_2);
            default:         taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch predictor with 2-bit saturating counters and a
// registered misprediction redirect. Lookup is combinational and sees the
// table contents before any same-cycle update.
// Optional feature macro: BRANCH_PREDICT_STATS_EN adds resolve/mispredict
// counters on stat_resolves / stat_mispredicts.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            resolve_valid,
    input  branch_op_t      resolve_op,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic [XLEN-1:0] operand_1,
    input  logic [XLEN-1:0] operand_2,
    input  logic [XLEN-1:0] operand_3,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PREDICT_STATS_EN
    ,
    output logic [31:0]     stat_resolves,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic               r_redirect_valid;
    logic [XLEN-1:0]    r_redirect_pc;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic               w_lk_hit;

    logic [IDX_W-1:0]   w_rs_idx;
    logic [TAG_W-1:0]   w_rs_tag;
    logic               w_rs_hit;
    logic               w_taken;
    logic [XLEN-1:0]    w_jalr_sum;
    logic [XLEN-1:0]    w_target;
    logic [XLEN-1:0]    w_fallthru;
    logic               w_mispredict;

    assign w_lk_idx = lookup_pc[IDX_W+1:2];
    assign w_lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    assign pred_target = w_lk_hit ? r_target[w_lk_idx] : (lookup_pc + XLEN'(4));

    branch_compare #(
        .XLEN (XLEN)
    ) u_compare (
        .operand_1 (operand_1),
        .operand_2 (operand_2),
        .op        (resolve_op),
        .taken     (w_taken)
    );

    assign w_rs_idx   = resolve_pc[IDX_W+1:2];
    assign w_rs_tag   = resolve_pc[XLEN-1:IDX_W+2];
    assign w_rs_hit   = r_valid[w_rs_idx] && (r_tag[w_rs_idx] == w_rs_tag);
    assign w_jalr_sum = operand_1 + operand_3;
    assign w_fallthru = resolve_pc + XLEN'(4);

    // Actual target: JALR is register-relative with bit 0 forced low, the rest PC-relative.
    always_comb begin
        w_target = resolve_pc + operand_3;
        if (resolve_op == OP_JALR) begin
            w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    // A wrong target only matters when the branch is actually taken.
    assign w_mispredict = (w_taken != resolve_pred_taken) ||
                          (w_taken && (w_target != resolve_pred_target));

    // Registered redirect towards fetch; redirect_pc holds between resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_redirect_valid <= resolve_valid && w_mispredict;
            if (resolve_valid) begin
                r_redirect_pc <= w_taken ? w_target : w_fallthru;
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;

    // Table training: allocate on tag miss, otherwise nudge the counter toward the outcome.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= WNT;
            end
        end else if (resolve_valid) begin
            if (!w_rs_hit) begin
                r_valid[w_rs_idx]  <= 1'b1;
                r_tag[w_rs_idx]    <= w_rs_tag;
                r_target[w_rs_idx] <= w_target;
                r_ctr[w_rs_idx]    <= w_taken ? WT : WNT;
            end else if (w_taken) begin
                r_target[w_rs_idx] <= w_target;
                if (r_ctr[w_rs_idx] != ST) begin
                    r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] + 2'd1;
                end
            end else if (r_ctr[w_rs_idx] != SNT) begin
                r_ctr[w_rs_idx] <= r_ctr[w_rs_idx] - 2'd1;
            end
        end
    end

`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0] r_stat_resolves;
    logic [31:0] r_stat_mispredicts;

    // Saturating event counters; they stick at all-ones rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_resolves    <= '0;
            r_stat_mispredicts <= '0;
        end else if (resolve_valid) begin
            if (r_stat_resolves != '1) begin
                r_stat_resolves <= r_stat_resolves + 32'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != '1)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

    assign stat_resolves    = r_stat_resolves;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a behavioural table model
// predicts lookups, and expected redirects are queued at stimulus time and
// popped when the registered redirect appears.
module tb_branch_predict_unit;
    import branch_pkg::*;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [XLEN-1:0]   lookup_pc = '0;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;
    logic              resolve_valid = 1'b0;
    branch_op_t        resolve_op = OP_BEQ;
    logic [XLEN-1:0]   resolve_pc = '0;
    logic [XLEN-1:0]   operand_1 = '0;
    logic [XLEN-1:0]   operand_2 = '0;
    logic [XLEN-1:0]   operand_3 = '0;
    logic              resolve_pred_taken = 1'b0;
    logic [XLEN-1:0]   resolve_pred_target = '0;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
`ifdef BRANCH_PREDICT_STATS_EN
    logic [31:0]       stat_resolves;
    logic [31:0]       stat_mispredicts;
`endif

    branch_predict_unit #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .lookup_pc           (lookup_pc),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target),
        .resolve_valid       (resolve_valid),
        .resolve_op          (resolve_op),
        .resolve_pc          (resolve_pc),
        .operand_1           (operand_1),
        .operand_2           (operand_2),
        .operand_3           (operand_3),
        .resolve_pred_taken  (resolve_pred_taken),
        .resolve_pred_target (resolve_pred_target),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc)
`ifdef BRANCH_PREDICT_STATS_EN
        ,
        .stat_resolves       (stat_resolves),
        .stat_mispredicts    (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            v;
        logic [XLEN-1:0] pc;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference table
    logic            m_valid  [ENTRIES];
    logic [25:0]     m_tag    [ENTRIES];
    logic [XLEN-1:0] m_target [ENTRIES];
    logic [1:0]      m_ctr    [ENTRIES];
    int              m_resolves;
    int              m_mispredicts;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = '0;
            m_target[i] = '0;
            m_ctr[i]    = 2'b01;
        end
        m_resolves    = 0;
        m_mispredicts = 0;
    endtask

    function automatic logic m_cond(branch_op_t op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            OP_JAL, OP_JALR: return 1'b1;
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BLT:  return $signed(a) < $signed(b);
            OP_BGE:  return $signed(a) >= $signed(b);
            OP_BLTU: return a < b;
            default: return a >= b;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] m_dest(branch_op_t op, logic [XLEN-1:0] pc,
                                               logic [XLEN-1:0] a, logic [XLEN-1:0] c);
        logic [XLEN-1:0] s;
        if (op == OP_JALR) begin
            s = a + c;
            s[0] = 1'b0;
            return s;
        end
        return pc + c;
    endfunction

    task automatic m_pred(input logic [XLEN-1:0] pc, output logic t, output logic [XLEN-1:0] tg);
        int  idx;
        logic hit;
        idx = int'(pc[5:2]);
        hit = m_valid[idx] && (m_tag[idx] == pc[31:6]);
        t   = hit && (m_ctr[idx] >= 2'b10);
        tg  = hit ? m_target[idx] : pc + 32'd4;
    endtask

    task automatic m_train(input logic [XLEN-1:0] pc, input logic t, input logic [XLEN-1:0] tg);
        int idx;
        idx = int'(pc[5:2]);
        if (!(m_valid[idx] && (m_tag[idx] == pc[31:6]))) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = pc[31:6];
            m_target[idx] = tg;
            m_ctr[idx]    = t ? 2'b10 : 2'b01;
        end else if (t) begin
            m_target[idx] = tg;
            if (m_ctr[idx] < 2'b11) m_ctr[idx] = m_ctr[idx] + 2'd1;
        end else if (m_ctr[idx] > 2'b00) begin
            m_ctr[idx] = m_ctr[idx] - 2'd1;
        end
    endtask

    task automatic check_lookup(input logic [XLEN-1:0] pc);
        logic            t;
        logic [XLEN-1:0] tg;
        lookup_pc = pc;
        #1;
        m_pred(pc, t, tg);
        check_val("lookup_taken", pred_taken, t);
        check_val("lookup_target", pred_target, tg);
    endtask

    // Called just after a rising edge; returns just after the edge carrying the redirect.
    task automatic do_resolve(input branch_op_t op, input logic [XLEN-1:0] pc,
                              input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                              input logic [XLEN-1:0] c, input logic pt,
                              input logic [XLEN-1:0] ptg);
        logic            t;
        logic [XLEN-1:0] tg;
        logic            mis;
        exp_t            e;
        t   = m_cond(op, a, b);
        tg  = m_dest(op, pc, a, c);
        mis = (t != pt) || (t && (tg != ptg));
        e.v  = mis;
        e.pc = t ? tg : pc + 32'd4;
        sb_q.push_back(e);
        resolve_op          = op;
        resolve_pc          = pc;
        operand_1           = a;
        operand_2           = b;
        operand_3           = c;
        resolve_pred_taken  = pt;
        resolve_pred_target = ptg;
        resolve_valid       = 1'b1;
        check_lookup(pc);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("redirect_valid", redirect_valid, e.v);
        check_val("redirect_pc", redirect_pc, e.pc);
        m_train(pc, t, tg);
        m_resolves++;
        if (mis) m_mispredicts++;
        resolve_valid = 1'b0;
    endtask

    task automatic do_resolve_pred(input branch_op_t op, input logic [XLEN-1:0] pc,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] c);
        logic            t;
        logic [XLEN-1:0] tg;
        m_pred(pc, t, tg);
        do_resolve(op, pc, a, b, c, t, tg);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        check_val("idle_redirect_valid", redirect_valid, 1'b0);
    endtask

    logic [XLEN-1:0] pc_set [5];
    logic [XLEN-1:0] op_set [5];
    logic [XLEN-1:0] imm_set [4];

    initial begin
        pc_set  = '{32'h100, 32'h140, 32'h104, 32'h2000, 32'hFFFF_FFFC};
        op_set  = '{32'h0, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h8000_0000};
        imm_set = '{32'h4, 32'h8, 32'h20, 32'hFFFF_FFF8};
        m_reset();

        // Reset behaviour
        #1 rst = 1'b1;
        lookup_pc = 32'h100;
        #1;
        check_val("rst_redirect_valid", redirect_valid, 1'b0);
        check_val("rst_redirect_pc", redirect_pc, 32'h0);
        check_val("rst_pred_taken", pred_taken, 1'b0);
        check_val("rst_pred_target", pred_target, 32'h104);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_lookup(32'h100);

        // BEQ taken, predicted not-taken
        do_resolve_pred(OP_BEQ, 32'h100, 32'd5, 32'd5, 32'h20);
        check_val("beq_redirect_valid", redirect_valid, 1'b1);
        check_val("beq_redirect_pc", redirect_pc, 32'h120);
        lookup_pc = 32'h100;
        #1;
        check_val("beq_pred_taken", pred_taken, 1'b1);
        check_val("beq_pred_target", pred_target, 32'h120);
        idle_cycle();

        // Unsigned versus signed compare of the same operands
        do_resolve_pred(OP_BLTU, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
        check_val("bltu_not_taken", redirect_valid, 1'b0);
        check_val("bltu_pc", redirect_pc, 32'h204);
        do_resolve_pred(OP_BLT, 32'h300, 32'hFFFF_FFFF, 32'd1, 32'h40);
        check_val("blt_taken", redirect_valid, 1'b1);
        check_val("blt_pc", redirect_pc, 32'h340);

        // JALR clears bit 0 and mismatches a not-taken prediction
        do_resolve(OP_JALR, 32'h400, 32'h1001, 32'h0, 32'h4, 1'b0, 32'h1004);
        check_val("jalr_redirect_valid", redirect_valid, 1'b1);
        check_val("jalr_redirect_pc", redirect_pc, 32'h1004);
        idle_cycle();

        // Counter saturation: four taken, then five not-taken
        for (int i = 0; i < 4; i++) begin
            do_resolve_pred(OP_BEQ, 32'h500, 32'd7, 32'd7, 32'h10);
            check_lookup(32'h500);
        end
        for (int i = 0; i < 5; i++) begin
            do_resolve_pred(OP_BNE, 32'h500, 32'd7, 32'd7, 32'h10);
            lookup_pc = 32'h500;
            #1;
            check_val("sat_pred_taken", pred_taken, (i == 0) ? 1'b1 : 1'b0);
        end
        do_resolve_pred(OP_BEQ, 32'h500, 32'd7, 32'd7, 32'h10);
        lookup_pc = 32'h500;
        #1;
        check_val("sat_floor_pred_taken", pred_taken, 1'b0);

        // Tag alias replaces the entry of 0x100
        do_resolve_pred(OP_BEQ, 32'h100 + 4 * ENTRIES, 32'd1, 32'd2, 32'h30);
        lookup_pc = 32'h100;
        #1;
        check_val("alias_old_taken", pred_taken, 1'b0);
        check_val("alias_old_target", pred_target, 32'h104);
        check_lookup(32'h100 + 4 * ENTRIES);

        // PC+4 wraps at the top of the address space
        do_resolve_pred(OP_BNE, 32'hFFFF_FFFC, 32'd3, 32'd3, 32'h8);
        check_val("wrap_redirect_pc", redirect_pc, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 60; i++) begin
            logic            t;
            logic [XLEN-1:0] tg;
            logic [XLEN-1:0] pc;
            pc = pc_set[$urandom_range(0, 4)];
            m_pred(pc, t, tg);
            if ($urandom_range(0, 3) == 0) t = ~t;
            do_resolve(branch_op_t'($urandom_range(0, 7)), pc,
                       op_set[$urandom_range(0, 4)], op_set[$urandom_range(0, 4)],
                       imm_set[$urandom_range(0, 3)], t, tg);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end
        for (int i = 0; i < 5; i++) check_lookup(pc_set[i]);

`ifdef BRANCH_PREDICT_STATS_EN
        check_val("stat_resolves", stat_resolves, m_resolves);
        check_val("stat_mispredicts", stat_mispredicts, m_mispredicts);
`endif

        // Resolve coinciding with reset is dropped
        resolve_op          = OP_JAL;
        resolve_pc          = 32'h900;
        operand_3           = 32'h80;
        resolve_pred_taken  = 1'b0;
        resolve_pred_target = 32'h904;
        resolve_valid       = 1'b1;
        rst                 = 1'b1;
        @(posedge clk);
        #1;
        rst           = 1'b0;
        resolve_valid = 1'b0;
        m_reset();
        check_val("rst_drop_redirect_valid", redirect_valid, 1'b0);
        check_val("rst_drop_redirect_pc", redirect_pc, 32'h0);
        check_lookup(32'h900);
        check_lookup(32'h100);
`ifdef BRANCH_PREDICT_STATS_EN
        check_val("stat_cleared", stat_resolves, 32'h0);
`endif
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
